// File: rtl/omsp_lpm_ctrl.sv
// Low-power-mode sequencer: turns CPUOFF/SCG1/OSCOFF requests into a safe sleep entry and exit.
// Define LPM_OSC_WAIT_EN to add the LFXT stabilisation wait (OSC_WAIT) after an OSCOFF sleep.
module omsp_lpm_ctrl #(
  parameter int OSC_STAB_EDGES = 4,
  parameter int OSC_TIMEOUT    = 1023
) (
  input  logic       mclk,
  input  logic       puc,
  input  logic       cpuoff_req,
  input  logic       scg1_req,
  input  logic       oscoff_req,
  input  logic       inst_done,
  input  logic       irq_pend,
  input  logic       nmi_pend,
  input  logic       lfxt_clk_en,
  output logic       mclk_en,
  output logic       scg1,
  output logic       oscoff,
  output logic       lpm_active,
  output logic       wake_irq,
  output logic [2:0] lpm_state
);

  typedef enum logic [2:0] {
    ACTIVE   = 3'd0,
    DRAIN    = 3'd1,
    SLEEP    = 3'd2,
    OSC_WAIT = 3'd3,
    RESUME   = 3'd4
  } lpm_state_e;

  lpm_state_e state, state_nxt;
  logic       wake;
  logic       mclk_en_nxt, scg1_nxt, oscoff_nxt, lpm_active_nxt, wake_irq_nxt;

  assign wake = irq_pend | nmi_pend;

`ifdef LPM_OSC_WAIT_EN
  localparam logic [3:0] STAB_EDGES = 4'(OSC_STAB_EDGES);
  localparam logic [9:0] TMO_LAST   = 10'(OSC_TIMEOUT - 1);

  logic [3:0] strobe_cnt;
  logic [9:0] tmo_cnt;
  logic       osc_done;

  // Counters idle at zero outside OSC_WAIT, so entry always starts a fresh count.
  always_ff @(posedge mclk) begin
    if (puc || state != OSC_WAIT) begin
      strobe_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      strobe_cnt <= strobe_cnt + 4'(lfxt_clk_en);
      tmo_cnt    <= tmo_cnt + 10'd1;
    end
  end

  assign osc_done = (lfxt_clk_en && ((strobe_cnt + 4'd1) == STAB_EDGES)) ||
                    (tmo_cnt == TMO_LAST);
`else
  logic unused_osc;
  assign unused_osc = lfxt_clk_en ^ (OSC_STAB_EDGES == 0) ^ (OSC_TIMEOUT == 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:   if (cpuoff_req && !wake) state_nxt = DRAIN;
      DRAIN: begin
        if (wake || !cpuoff_req) state_nxt = ACTIVE;
        else if (inst_done)      state_nxt = SLEEP;
      end
      SLEEP: begin
        if (wake) begin
`ifdef LPM_OSC_WAIT_EN
          state_nxt = oscoff ? OSC_WAIT : RESUME;
`else
          state_nxt = RESUME;
`endif
        end
      end
`ifdef LPM_OSC_WAIT_EN
      OSC_WAIT: if (osc_done) state_nxt = RESUME;
`endif
      RESUME:   state_nxt = ACTIVE;
      default:  state_nxt = ACTIVE;
    endcase

    // Outputs are a function of the upcoming state so they can be registered alongside it.
    mclk_en_nxt    = !(state_nxt == SLEEP || state_nxt == OSC_WAIT);
    lpm_active_nxt = (state_nxt == SLEEP || state_nxt == OSC_WAIT);
    wake_irq_nxt   = (state_nxt == RESUME);
    scg1_nxt       = 1'b0;
    oscoff_nxt     = 1'b0;
    // The scg1/oscoff registers double as the request latches while sleeping.
    if (state_nxt == SLEEP) begin
      scg1_nxt   = (state == DRAIN) ? scg1_req   : scg1;
      oscoff_nxt = (state == DRAIN) ? oscoff_req : oscoff;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc) begin
      state      <= ACTIVE;
      mclk_en    <= 1'b1;
      scg1       <= 1'b0;
      oscoff     <= 1'b0;
      lpm_active <= 1'b0;
      wake_irq   <= 1'b0;
    end else begin
      state      <= state_nxt;
      mclk_en    <= mclk_en_nxt;
      scg1       <= scg1_nxt;
      oscoff     <= oscoff_nxt;
      lpm_active <= lpm_active_nxt;
      wake_irq   <= wake_irq_nxt;
    end
  end

  assign lpm_state = state;

endmodule

// File: tb/tb_omsp_lpm_ctrl.sv
// Scoreboard bench for omsp_lpm_ctrl: a behavioural model queues expected outputs per cycle,
// a monitor compares them after each edge; directed latency checks cover the wake sequences.
module tb_omsp_lpm_ctrl;

  localparam int EDGES = 4;
  localparam int TMO   = 16;
`ifdef LPM_OSC_WAIT_EN
  localparam bit OSC_EN = 1'b1;
`else
  localparam bit OSC_EN = 1'b0;
`endif

  logic       mclk = 1'b0;
  logic       puc, cpuoff_req, scg1_req, oscoff_req, inst_done, irq_pend, nmi_pend, lfxt_clk_en;
  logic       mclk_en, scg1, oscoff, lpm_active, wake_irq;
  logic [2:0] lpm_state;

  omsp_lpm_ctrl #(.OSC_STAB_EDGES(EDGES), .OSC_TIMEOUT(TMO)) dut (
    .mclk(mclk), .puc(puc), .cpuoff_req(cpuoff_req), .scg1_req(scg1_req),
    .oscoff_req(oscoff_req), .inst_done(inst_done), .irq_pend(irq_pend),
    .nmi_pend(nmi_pend), .lfxt_clk_en(lfxt_clk_en), .mclk_en(mclk_en), .scg1(scg1),
    .oscoff(oscoff), .lpm_active(lpm_active), .wake_irq(wake_irq), .lpm_state(lpm_state)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got 'h%0h expected 'h%0h", name, $time, act, exp);
  endfunction

  // Behavioural model: phase 0 run, 1 draining, 2 asleep, 3 waiting on LFXT, 4 resuming.
  int m_phase = 0;
  bit m_scg1_l, m_osc_l;
  int m_strobes, m_waited;

  function automatic void model_step();
    bit w;
    w = irq_pend | nmi_pend;
    if (puc) begin
      m_phase = 0; m_scg1_l = 0; m_osc_l = 0; m_strobes = 0; m_waited = 0;
      return;
    end
    if (m_phase == 0) begin
      if (cpuoff_req && !w) m_phase = 1;
    end else if (m_phase == 1) begin
      if (w || !cpuoff_req) m_phase = 0;
      else if (inst_done) begin
        m_phase = 2; m_scg1_l = scg1_req; m_osc_l = oscoff_req;
      end
    end else if (m_phase == 2) begin
      if (w) begin
        if (OSC_EN && m_osc_l) begin
          m_phase = 3; m_strobes = 0; m_waited = 0;
        end else m_phase = 4;
      end
    end else if (m_phase == 3) begin
      m_strobes += int'(lfxt_clk_en);
      if (m_strobes == EDGES || m_waited == TMO - 1) m_phase = 4;
      else m_waited++;
    end else m_phase = 0;
  endfunction

  function automatic logic [7:0] model_out();
    bit sl;
    sl = (m_phase == 2 || m_phase == 3);
    return {!sl, (m_phase == 2) & m_scg1_l, (m_phase == 2) & m_osc_l, sl,
            m_phase == 4, 3'(m_phase)};
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always @(posedge mclk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      chk("outputs{mclk_en,scg1,oscoff,lpm_active,wake_irq,state}",
          int'({mclk_en, scg1, oscoff, lpm_active, wake_irq, lpm_state}), int'(mon_exp));
    end
  end

  task automatic tick();
    model_step();
    exp_q.push_back(model_out());
    @(negedge mclk);
  endtask

  task automatic idle_inputs();
    puc = 0; cpuoff_req = 0; scg1_req = 0; oscoff_req = 0;
    inst_done = 0; irq_pend = 0; nmi_pend = 0; lfxt_clk_en = 0;
  endtask

  task automatic enter_sleep(input bit s, input bit o);
    cpuoff_req = 1; scg1_req = s; oscoff_req = o; irq_pend = 0; nmi_pend = 0;
    tick(); tick(); tick();
    inst_done = 1; tick();
    inst_done = 0; tick();
    chk("sleep_state", int'(lpm_state), 2);
    chk("sleep_mclk_en", int'(mclk_en), 0);
  endtask

  // Raise irq in SLEEP and count cycles until wake_irq shows; strobes on cycles 1,3,6,9,12 if asked.
  task automatic wake_latency(input string name, input bit strobes, input int exp_lat);
    int lat = 0;
    irq_pend = 1;
    for (int k = 1; k <= 40; k++) begin
      lfxt_clk_en = strobes && k <= 12 && (k == 1 || k % 3 == 0);
      tick();
      if (wake_irq) begin lat = k; break; end
    end
    lfxt_clk_en = 0;
    chk(name, lat, exp_lat);
    tick();
    chk({name, "_back_active"}, int'(lpm_state), 0);
    cpuoff_req = 0; irq_pend = 0; oscoff_req = 0; scg1_req = 0;
    tick(); tick();
  endtask

  initial begin
    idle_inputs();
    puc = 1;
    tick(); tick();
    chk("reset_state", int'(lpm_state), 0);
    chk("reset_mclk_en", int'(mclk_en), 1);
    chk("reset_clk_ctrl", int'({scg1, oscoff, wake_irq, lpm_active}), 0);
    puc = 0;
    tick();

    // Entry with SCG1, plain interrupt exit.
    enter_sleep(1'b1, 1'b0);
    chk("sleep_scg1", int'(scg1), 1);
    tick(); tick();
    wake_latency("exit_plain_latency", 1'b0, 1);

    // Abort: interrupt coincides with inst_done while draining.
    cpuoff_req = 1; tick();
    chk("drain_state", int'(lpm_state), 1);
    inst_done = 1; irq_pend = 1; tick();
    chk("abort_to_active", int'(lpm_state), 0);
    chk("abort_mclk_en", int'(mclk_en), 1);
    inst_done = 0; irq_pend = 0; cpuoff_req = 0; tick();

    // Oscillator wait with strobes (the one on the transition cycle must not count).
    enter_sleep(1'b0, 1'b1);
    chk("sleep_oscoff", int'(oscoff), 1);
    wake_latency("osc_strobe_latency", 1'b1, OSC_EN ? 12 : 1);

    // Timeout with no strobes.
    enter_sleep(1'b1, 1'b1);
    wake_latency("osc_timeout_latency", 1'b0, OSC_EN ? TMO + 1 : 1);

    // NMI wakes as well.
    enter_sleep(1'b0, 1'b0);
    nmi_pend = 1; tick();
    chk("nmi_wake_irq", int'(wake_irq), 1);
    nmi_pend = 0; cpuoff_req = 0; tick(); tick();

    // puc held two cycles while asleep.
    enter_sleep(1'b1, 1'b1);
    puc = 1; tick(); tick();
    chk("puc_in_sleep_state", int'(lpm_state), 0);
    chk("puc_in_sleep_outs", int'({mclk_en, scg1, oscoff}), 3'b100);
    idle_inputs(); tick();

    // Randomised traffic, checked cycle by cycle through the scoreboard.
    for (int i = 0; i < 600; i++) begin
      puc         = ($urandom_range(99) < 2);
      cpuoff_req  = ($urandom_range(99) < 75);
      scg1_req    = $urandom_range(1);
      oscoff_req  = $urandom_range(1);
      inst_done   = ($urandom_range(99) < 35);
      irq_pend    = ($urandom_range(99) < 6);
      nmi_pend    = ($urandom_range(99) < 3);
      lfxt_clk_en = ($urandom_range(99) < 20);
      tick();
    end
    idle_inputs(); tick(); tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
